// File: rtl/sid_pkg.sv
// Shared constants and types for the multi-voice SID SPI register bank.
package sid_pkg;

    localparam logic [2:0] REG_FREQ_LO = 3'd0;
    localparam logic [2:0] REG_FREQ_HI = 3'd1;
    localparam logic [2:0] REG_PW_LO   = 3'd2;
    localparam logic [2:0] REG_PW_HI   = 3'd3;
    localparam logic [2:0] REG_ATTACK  = 3'd4;
    localparam logic [2:0] REG_SUSTAIN = 3'd5;
    localparam logic [2:0] REG_WAVE    = 3'd6;
    localparam logic [2:0] REG_CTRL    = 3'd7;

    localparam int RW_BIT    = 15;
    localparam int VOICE_MSB = 14;
    localparam int VOICE_LSB = 11;
    localparam int REG_MSB   = 10;
    localparam int REG_LSB   = 8;

    // Offset of the header byte inside the 16-bit frame.
    localparam int HDR_OFS = 8;

    localparam logic [3:0] BROADCAST_VOICE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DONE
    } spi_state_t;

endpackage

// File: rtl/sid_spi_sync.sv
// Synchronises the asynchronous SPI pins into clk and detects spi_clk edges.
module sid_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= '0;
            cs_q      <= '1;
            mosi_q    <= '0;
            sclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage samples the previous stage's old value.
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
            cs_q      <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev;
    assign cs_n      = cs_q[SYNC_STAGES-1];
    assign mosi      = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/sid_spi_regbank.sv
// SPI slave serving NUM_VOICES SID voices with readback and optional shadow/commit registers.
module sid_spi_regbank
    import sid_pkg::*;
#(
    parameter int NUM_VOICES  = 3,
    parameter int SHADOW      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_clk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic [16*NUM_VOICES-1:0] sid_frequency,
    output logic [16*NUM_VOICES-1:0] sid_duration,
    output logic [8*NUM_VOICES-1:0]  sid_attack,
    output logic [8*NUM_VOICES-1:0]  sid_sustain,
    output logic [8*NUM_VOICES-1:0]  sid_waveform,
    output logic [NUM_VOICES-1:0]    voice_update
);

    typedef logic [6:0][7:0] voice_regs_t;

    logic            sclk_rise, sclk_fall, cs_n, mosi;
    spi_state_t      state;
    logic [3:0]      bit_cnt;
    logic [13:0]     shift_q;
    logic            is_read;
    logic [7:0]      tx_q;
    logic            exec_q;
    logic [14:0]     frame_q;
    logic [7:0]      hdr_next;
    logic [3:0]      hdr_voice;
    logic [2:0]      hdr_reg;
    logic [7:0]      rd_byte;
    logic [3:0]      w_voice;
    logic [2:0]      w_reg;
    logic [7:0]      w_data;
    logic [NUM_VOICES-1:0] pending;
    voice_regs_t     live   [NUM_VOICES];
    voice_regs_t     shadow [NUM_VOICES];

    sid_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_n      (cs_n),
        .mosi      (mosi)
    );

    assign hdr_next  = {shift_q[6:0], mosi};
    assign hdr_voice = hdr_next[VOICE_MSB-HDR_OFS:VOICE_LSB-HDR_OFS];
    assign hdr_reg   = hdr_next[REG_MSB-HDR_OFS:REG_LSB-HDR_OFS];
    assign w_voice   = frame_q[VOICE_MSB:VOICE_LSB];
    assign w_reg     = frame_q[REG_MSB:REG_LSB];
    assign w_data    = frame_q[7:0];

    always_comb begin
        // NOTE: default first so no path leaves rd_byte unassigned (no latch).
        rd_byte = 8'h00;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (hdr_voice == 4'(v)) begin
                if (hdr_reg == REG_CTRL) rd_byte = {7'b0, pending[v]};
                else if (SHADOW != 0)    rd_byte = shadow[v][hdr_reg];
                else                     rd_byte = live[v][hdr_reg];
            end
        end
    end

    // Frame FSM; the write itself is executed one clk after the 16th edge via exec_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            is_read  <= 1'b0;
            tx_q     <= '0;
            exec_q   <= 1'b0;
            frame_q  <= '0;
            spi_miso <= 1'b0;
        end else begin
            exec_q <= 1'b0;
            if (cs_n) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                is_read  <= 1'b0;
                spi_miso <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state   <= ST_HEADER;
                        bit_cnt <= '0;
                    end
                    ST_HEADER: if (sclk_rise) begin
                        shift_q <= {shift_q[12:0], mosi};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state   <= ST_DATA;
                            is_read <= hdr_next[RW_BIT-HDR_OFS];
                            tx_q    <= rd_byte;
                        end
                    end
                    ST_DATA: if (sclk_rise) begin
                        shift_q <= {shift_q[12:0], mosi};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state    <= ST_DONE;
                            spi_miso <= 1'b0;
                            if (!is_read) begin
                                frame_q <= {shift_q, mosi};
                                exec_q  <= 1'b1;
                            end
                        end
                    end else if (sclk_fall && is_read) begin
                        spi_miso <= tx_q[7];
                        tx_q     <= {tx_q[6:0], 1'b0};
                    end
                    ST_DONE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: register storage is reset explicitly because live bytes drive the voices directly.
            for (int v = 0; v < NUM_VOICES; v++) begin
                live[v]   <= '0;
                shadow[v] <= '0;
            end
            voice_update <= '0;
        end else begin
            voice_update <= '0;
            if (exec_q) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (w_reg == REG_CTRL) begin
                        if (SHADOW != 0 && w_data[0] &&
                            (w_voice == BROADCAST_VOICE || w_voice == 4'(v))) begin
                            live[v]         <= shadow[v];
                            voice_update[v] <= 1'b1;
                        end
                    end else if (w_voice == 4'(v)) begin
                        if (SHADOW != 0) begin
                            shadow[v][w_reg] <= w_data;
                        end else begin
                            live[v][w_reg]  <= w_data;
                            voice_update[v] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign pending[v] = (SHADOW != 0) && (shadow[v] != live[v]);
        assign sid_frequency[16*v +: 16] = {live[v][REG_FREQ_HI], live[v][REG_FREQ_LO]};
        assign sid_duration[16*v +: 16]  = {live[v][REG_PW_HI], live[v][REG_PW_LO]};
        assign sid_attack[8*v +: 8]      = live[v][REG_ATTACK];
        assign sid_sustain[8*v +: 8]     = live[v][REG_SUSTAIN];
        assign sid_waveform[8*v +: 8]    = live[v][REG_WAVE];
    end

endmodule

// File: tb/tb_sid_spi_regbank.sv
// Bench for sid_spi_regbank: one direct-write instance and one shadowed instance against a byte-array model.
module tb_sid_spi_regbank;

    localparam int NV   = 3;
    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic [1:0] cs_n = 2'b11;
    logic [1:0] miso;
    logic [16*NV-1:0] freq [2];
    logic [16*NV-1:0] dur  [2];
    logic [8*NV-1:0]  att  [2];
    logic [8*NV-1:0]  sus  [2];
    logic [8*NV-1:0]  wav  [2];
    logic [NV-1:0]    upd  [2];

    logic [7:0] sh_m [2][NV][7];
    logic [7:0] lv_m [2][NV][7];
    int exp_upd [2][NV];
    int cnt [2][NV];
    int bcast_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sid_spi_regbank #(.NUM_VOICES(NV), .SHADOW(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs_n[0]), .spi_mosi(spi_mosi),
        .spi_miso(miso[0]), .sid_frequency(freq[0]), .sid_duration(dur[0]), .sid_attack(att[0]),
        .sid_sustain(sus[0]), .sid_waveform(wav[0]), .voice_update(upd[0])
    );

    sid_spi_regbank #(.NUM_VOICES(NV), .SHADOW(1), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs_n[1]), .spi_mosi(spi_mosi),
        .spi_miso(miso[1]), .sid_frequency(freq[1]), .sid_duration(dur[1]), .sid_attack(att[1]),
        .sid_sustain(sus[1]), .sid_waveform(wav[1]), .voice_update(upd[1])
    );

    initial begin
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < NV; v++) begin
                cnt[d][v] = 0;
                exp_upd[d][v] = 0;
            end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < NV; v++)
                if (upd[d][v] === 1'b1) cnt[d][v] <= cnt[d][v] + 1;
        if (upd[1] === 3'b111) bcast_cnt <= bcast_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < NV; v++)
                for (int r = 0; r < 7; r++) begin
                    sh_m[d][v][r] = 8'h00;
                    lv_m[d][v][r] = 8'h00;
                end
    endfunction

    function automatic void mdl_write(input int d, input int voice, input int r, input logic [7:0] data);
        if (d == 1) begin
            if (r == 7) begin
                if (data[0])
                    for (int v = 0; v < NV; v++)
                        if (voice == 15 || voice == v) begin
                            for (int k = 0; k < 7; k++) lv_m[1][v][k] = sh_m[1][v][k];
                            exp_upd[1][v]++;
                        end
            end else if (voice < NV) begin
                sh_m[1][voice][r] = data;
            end
        end else if (r != 7 && voice < NV) begin
            lv_m[0][voice][r] = data;
            exp_upd[0][voice]++;
        end
    endfunction

    function automatic logic [7:0] mdl_read(input int d, input int voice, input int r);
        if (voice >= NV) return 8'h00;
        if (r == 7) begin
            if (d == 0) return 8'h00;
            for (int k = 0; k < 7; k++)
                if (sh_m[1][voice][k] != lv_m[1][voice][k]) return 8'h01;
            return 8'h00;
        end
        return (d == 1) ? sh_m[1][voice][r] : lv_m[0][voice][r];
    endfunction

    task automatic shift_bits(input int d, input logic [15:0] word, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = word[15-i];
            #HALF;
            rx[15-i] = miso[d];
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input int d, input logic [15:0] word, input int n, output logic [15:0] rx);
        cs_n[d] = 1'b0;
        #HALF;
        shift_bits(d, word, n, rx);
        #HALF;
        cs_n[d] = 1'b1;
        #(4*HALF);
    endtask

    task automatic do_write(input int d, input int voice, input int r, input logic [7:0] data);
        logic [15:0] rx;
        frame(d, {1'b0, 4'(voice), 3'(r), data}, 16, rx);
        check($sformatf("miso_on_write d%0d", d), rx, 16'h0000);
        mdl_write(d, voice, r, data);
    endtask

    task automatic do_read(input int d, input int voice, input int r, output logic [7:0] val);
        logic [15:0] rx;
        frame(d, {1'b1, 4'(voice), 3'(r), 8'h00}, 16, rx);
        check($sformatf("miso_hdr d%0d v%0d r%0d", d, voice, r), rx[15:8], 8'h00);
        check($sformatf("read d%0d v%0d r%0d", d, voice, r), rx[7:0], mdl_read(d, voice, r));
        val = rx[7:0];
    endtask

    task automatic check_outputs(input int d);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("freq d%0d v%0d", d, v), freq[d][16*v +: 16], {lv_m[d][v][1], lv_m[d][v][0]});
            check($sformatf("dur d%0d v%0d", d, v), dur[d][16*v +: 16], {lv_m[d][v][3], lv_m[d][v][2]});
            check($sformatf("att d%0d v%0d", d, v), att[d][8*v +: 8], lv_m[d][v][4]);
            check($sformatf("sus d%0d v%0d", d, v), sus[d][8*v +: 8], lv_m[d][v][5]);
            check($sformatf("wav d%0d v%0d", d, v), wav[d][8*v +: 8], lv_m[d][v][6]);
            check($sformatf("upd_cnt d%0d v%0d", d, v), cnt[d][v], exp_upd[d][v]);
        end
        check($sformatf("miso_idle d%0d", d), miso[d], 1'b0);
    endtask

    initial begin
        logic [7:0]  val;
        logic [15:0] rx;
        int b0;
        int voices [6];
        voices = '{0, 1, 2, 3, 5, 15};

        mdl_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs(0);
        check_outputs(1);
        check("upd_reset d1", upd[1], 3'b000);

        // Direct writes assemble a 16-bit frequency and pulse once per write.
        do_write(0, 1, 0, 8'h34);
        do_write(0, 1, 1, 8'h12);
        check("tp_freq_v1", freq[0][31:16], 16'h1234);
        check("tp_upd_v1", cnt[0][1], 2);
        check_outputs(0);

        // Shadowed write stays pending until committed.
        do_write(1, 0, 4, 8'hA5);
        check("tp_att_pre", att[1][7:0], 8'h00);
        do_read(1, 0, 7, val);
        check("tp_pending_set", val, 8'h01);
        do_write(1, 0, 7, 8'h01);
        check("tp_att_post", att[1][7:0], 8'hA5);
        check("tp_upd_commit", cnt[1][0], 1);
        do_read(1, 0, 7, val);
        check("tp_pending_clr", val, 8'h00);
        check_outputs(1);

        // Readback of a waveform byte.
        do_write(1, 2, 6, 8'h41);
        do_read(1, 2, 6, val);
        check("tp_read_wave", val, 8'h41);
        do_write(0, 2, 6, 8'h5C);
        do_read(0, 2, 6, val);
        check("tp_read_live", val, 8'h5C);

        // Broadcast commit updates every voice in the same clk.
        do_write(1, 0, 6, 8'h11);
        do_write(1, 1, 6, 8'h21);
        do_write(1, 2, 6, 8'h81);
        check("tp_wav_precommit", wav[1], 24'h000000);
        b0 = bcast_cnt;
        do_write(1, 15, 7, 8'h01);
        check("tp_bcast_same_clk", bcast_cnt - b0, 1);
        check("tp_bcast_wav", wav[1], 24'h812111);
        check_outputs(1);

        // Aborted frame has no effect; the next full frame lands.
        frame(0, {1'b0, 4'd0, 3'd2, 8'h77}, 10, rx);
        check_outputs(0);
        do_write(0, 0, 2, 8'h77);
        check("tp_after_abort", dur[0][7:0], 8'h77);
        check_outputs(0);

        // Out-of-range voice is ignored and reads as zero.
        do_write(1, 5, 0, 8'h99);
        do_write(1, 5, 7, 8'h01);
        do_read(1, 5, 0, val);
        check("tp_oor_read", val, 8'h00);
        do_write(0, 5, 0, 8'h99);
        check_outputs(0);
        check_outputs(1);

        for (int i = 0; i < 60; i++) begin
            int d, voice, r;
            logic [7:0] data;
            d = int'($urandom_range(0, 1));
            voice = voices[$urandom_range(0, 5)];
            r = int'($urandom_range(0, 7));
            data = 8'($urandom);
            if ($urandom_range(0, 2) == 0) do_read(d, voice, r, val);
            else do_write(d, voice, r, data);
            check_outputs(d);
        end

        // Reset in the middle of a frame discards it and clears everything.
        do_write(0, 2, 5, 8'h3C);
        @(negedge clk);
        cs_n[1] = 1'b0;
        #HALF;
        shift_bits(1, {1'b0, 4'd1, 3'd7, 8'h01}, 6, rx);
        rst = 1'b1;
        #HALF;
        cs_n[1] = 1'b1;
        #HALF;
        rst = 1'b0;
        mdl_reset();
        #(2*HALF);
        check_outputs(0);
        check_outputs(1);
        do_write(0, 0, 0, 8'hE7);
        check("tp_post_reset_write", freq[0][15:0], 16'h00E7);
        check_outputs(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sid_spi_regbank.md
Name: sid_spi_regbank

Overview:
- Parametrised successor to the single-voice, write-only SPI register bank. Serves NUM_VOICES SID voices through one SPI slave (CPOL=0, CPHA=0, MSB first, 16-bit frames).
- Supports register readback on MISO and optional double-buffered shadow registers with an atomic per-voice commit.
- Sits between the top-level pin wrapper and an array of sid_voice instances. All registers are in the clk domain.

Parameters:
- NUM_VOICES, 3, number of voices served; legal range 1..16.
- SHADOW, 1, 1 = writes land in shadow registers and reach live outputs only on commit; 0 = writes go straight to live registers.
- SYNC_STAGES, 2, synchroniser depth on spi_clk, spi_cs_n and spi_mosi; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the spi_clk frequency.
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI serial clock, asynchronous.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out; 0 outside the read data phase.
- sid_frequency  out  16*NUM_VOICES  per-voice frequency {freq_hi, freq_lo}; voice v occupies [16v+15:16v].
- sid_duration  out  16*NUM_VOICES  per-voice pulse width {pw_hi, pw_lo}.
- sid_attack  out  8*NUM_VOICES  per-voice attack/decay byte.
- sid_sustain  out  8*NUM_VOICES  per-voice sustain/release byte.
- sid_waveform  out  8*NUM_VOICES  per-voice waveform/control byte.
- voice_update  out  NUM_VOICES  one-cycle pulse when any live register of voice v changes value source (write or commit).

Behaviour:
- Frame fields:
  - [15] rw (1 = read).
  - [14:11] voice index.
  - [10:8] register: 0 freq_lo, 1 freq_hi, 2 pw_lo, 3 pw_hi, 4 attack, 5 sustain, 6 waveform, 7 control.
  - [7:0] data; ignored on reads.
- Synchronisation: the three SPI inputs pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised spi_clk.
- FSM states:
  - IDLE: wait for synchronised cs_n to go low, then go to HEADER with bit count 0.
  - HEADER: shift 8 MOSI bits on spi_clk rising edges. After the 8th bit:
    - if rw=1, load the addressed byte into the TX shift register and go to DATA;
    - if rw=0, go to DATA.
  - DATA: shift 8 more bits. A read shifts the TX register out. After the 16th rising edge, go to DONE and execute the write on the next clk.
  - DONE: ignore further edges until cs_n goes high, then return to IDLE.
- Abort: cs_n deasserted in any state returns the FSM to IDLE. No write occurs. A partial frame has no side effects.
- MISO timing:
  - The read data MSB appears on the first synchronised spi_clk falling edge after the 8th rising edge.
  - Each subsequent falling edge advances one bit.
  - spi_miso is 0 in IDLE, HEADER and DONE, and during write frames.
- Write, SHADOW=1:
  - A write to registers 0..6 updates the shadow only.
  - A write to register 7 with data[0]=1 copies all 7 shadow bytes of that voice to live in one clk and pulses voice_update[v]. data[0]=0 is a no-op.
  - Voice index 15 with register 7 is a broadcast commit to all voices in the same cycle.
- Write, SHADOW=0: a write to registers 0..6 updates live directly and pulses voice_update[v]. Register 7 writes are ignored.
- Read:
  - Registers 0..6 return shadow when SHADOW=1, live when SHADOW=0.
  - Register 7 returns {7'b0, pending}, where pending=1 if any shadow byte of the voice differs from live. It is always 0 when SHADOW=0.
- Out-of-range voice (voice >= NUM_VOICES, except the broadcast case): writes are dropped and reads return 8'h00.
- Latency: a write reaches live outputs SYNC_STAGES+2 clk cycles after the 16th spi_clk rising edge arrives at the pin.
- Reset: every shadow and live byte is 0, voice_update=0, spi_miso=0, FSM in IDLE, bit count 0. Reset mid-frame discards the frame.

Decomposition:
- Package sid_pkg holds:
  - register index constants REG_FREQ_LO..REG_CTRL;
  - field positions RW_BIT, VOICE_MSB/LSB, REG_MSB/LSB;
  - BROADCAST_VOICE=4'hF.
- One natural sub-module: sid_spi_sync (synchroniser chain plus rising/falling edge detect for the three inputs).

Test Plan:
- SHADOW=0: write voice 1 reg 0=0x34, then reg 1=0x12 -> sid_frequency[31:16]=0x1234; voice_update[1] pulses twice; voices 0 and 2 unchanged.
- SHADOW=1: write voice 0 attack=0xA5 -> live attack stays 0x00 and reg 7 read returns 0x01. Write reg 7=0x01 -> live becomes 0xA5, voice_update[0] pulses once, and a reg 7 read then returns 0x00.
- Read voice 2 waveform after writing 0x41 -> MISO bits 8..15 return 0x41; MISO is 0 during bits 0..7.
- Broadcast: shadow-write distinct waveforms to voices 0..2, then write voice 15 reg 7=0x01 -> all three live waveforms update on the same clk; voice_update=3'b111 for one cycle.
- Abort: raise cs_n after 10 bits of a write frame -> no register change. The next full frame completes correctly.
- Out-of-range voice 5 (NUM_VOICES=3) write/read -> no change, read returns 0x00. Asserting rst mid-frame -> all outputs return to 0.
